// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: merges button/periodic requests, enforces the sensor
// inter-read gap, supervises each attempt with a timeout and retries bad frames.
module dht11_read_scheduler #(
  parameter int MIN_GAP_CYC = 200_000_000,
  parameter int TIMEOUT_CYC = 3_000_000,
  parameter int PERIOD_CYC  = 500_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn,
  input  logic        i_auto_en,
  output logic        o_sens_start,
  input  logic        i_sens_frame_valid,
  input  logic [39:0] i_sens_frame,
  output logic [7:0]  o_temp,
  output logic [7:0]  o_hum,
  output logic        o_data_valid,
  output logic        o_upd,
  output logic        o_fail,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CHECK, S_RETRY, S_GAP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_btn_ff;
  logic [31:0] r_per_cnt, r_tmo_cnt, r_gap_cnt;
  logic        r_pending, r_retry_req;
  logic [3:0]  r_retry_cnt;
  logic [39:0] r_frame;
  logic [7:0]  r_temp, r_hum, r_err_cnt;
  logic        r_data_valid, r_upd, r_fail, r_sens_start;

  logic        w_btn_req, w_per_req, w_req;
  logic        w_tmo_done, w_gap_done, w_can_retry, w_cks_ok;
  logic [7:0]  w_sum;
  logic        w_start, w_upd, w_fail, w_err;

  assign w_btn_req   = r_btn_ff[1] & ~r_btn_ff[2];
  assign w_per_req   = i_auto_en && (r_per_cnt == 32'(PERIOD_CYC - 1));
  assign w_req       = w_btn_req | w_per_req;
  assign w_tmo_done  = (r_tmo_cnt == 32'(TIMEOUT_CYC - 1));
  assign w_gap_done  = (r_gap_cnt == 32'(MIN_GAP_CYC - 1));
  assign w_can_retry = (r_retry_cnt < 4'(MAX_RETRY));
  assign w_sum       = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
  assign w_cks_ok    = (w_sum == r_frame[7:0]);

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_pending) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_sens_frame_valid) w_state_nxt = S_CHECK;
        else if (w_tmo_done)    w_state_nxt = S_RETRY;
      end
      S_CHECK: w_state_nxt = w_cks_ok ? S_GAP : S_RETRY;
      S_RETRY: w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_done) w_state_nxt = r_retry_req ? S_START : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs, registered below so every port comes from a flop
  always_comb begin
    w_start = (w_state_nxt == S_START);
    w_upd   = (r_state == S_CHECK) && w_cks_ok;
    w_fail  = (r_state == S_RETRY) && !w_can_retry;
    w_err   = ((r_state == S_WAIT) && !i_sens_frame_valid && w_tmo_done) ||
              ((r_state == S_CHECK) && !w_cks_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_ff     <= '0;
      r_per_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_pending    <= 1'b0;
      r_retry_req  <= 1'b0;
      r_retry_cnt  <= '0;
      r_frame      <= '0;
      r_temp       <= '0;
      r_hum        <= '0;
      r_err_cnt    <= '0;
      r_data_valid <= 1'b0;
      r_upd        <= 1'b0;
      r_fail       <= 1'b0;
      r_sens_start <= 1'b0;
    end else begin
      r_btn_ff <= {r_btn_ff[1:0], i_btn};

      if (!i_auto_en || w_per_req) r_per_cnt <= '0;
      else                         r_per_cnt <= r_per_cnt + 32'd1;

      // A request landing on the IDLE->START cycle merges into that read
      if (r_state == S_IDLE && r_pending) r_pending <= 1'b0;
      else if (w_req)                     r_pending <= 1'b1;

      // Timeout counts from the START cycle, so it expires TIMEOUT_CYC after it
      if (r_state == S_START || r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 32'd1;
      else                                         r_tmo_cnt <= '0;

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 32'd1;
      else                  r_gap_cnt <= '0;

      if (r_state == S_WAIT && i_sens_frame_valid) r_frame <= i_sens_frame;

      if (r_state == S_RETRY) begin
        if (w_can_retry) begin
          r_retry_cnt <= r_retry_cnt + 4'd1;
          r_retry_req <= 1'b1;
        end else begin
          r_retry_cnt <= '0;
          r_retry_req <= 1'b0;
        end
      end else if (r_state == S_GAP && w_state_nxt == S_START) begin
        r_retry_req <= 1'b0;
      end else if (w_upd) begin
        r_retry_cnt <= '0;
      end

      if (w_upd) begin
        r_temp       <= r_frame[23:16];
        r_hum        <= r_frame[39:32];
        r_data_valid <= 1'b1;
      end

      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

      r_upd        <= w_upd;
      r_fail       <= w_fail;
      r_sens_start <= w_start;
    end
  end

  assign o_sens_start = r_sens_start;
  assign o_temp       = r_temp;
  assign o_hum        = r_hum;
  assign o_data_valid = r_data_valid;
  assign o_upd        = r_upd;
  assign o_fail       = r_fail;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed bench for dht11_read_scheduler: sensor responder, event monitor and
// a temp/hum scoreboard filled as good frames are driven.
module tb_dht11_read_scheduler;
  localparam int G = 100, T = 500, P = 2000, R = 2;

  logic        clk = 1'b0, rst = 1'b1, btn = 1'b0, auto_en = 1'b0, fv = 1'b0;
  logic [39:0] frame = '0;
  logic        sens_start, data_valid, upd, fail;
  logic [7:0]  temp, hum, err_cnt;

  dht11_read_scheduler #(.MIN_GAP_CYC(G), .TIMEOUT_CYC(T), .PERIOD_CYC(P), .MAX_RETRY(R)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_auto_en(auto_en),
    .o_sens_start(sens_start), .i_sens_frame_valid(fv), .i_sens_frame(frame),
    .o_temp(temp), .o_hum(hum), .o_data_valid(data_valid), .o_upd(upd),
    .o_fail(fail), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int n_start = 0, n_upd = 0, n_fail = 0, multi = 0;
  int start_cyc[$], err_cyc[$], upd_cyc[$];
  logic [15:0] obs[$], expq[$];
  logic prev_s = 0, prev_u = 0, prev_f = 0;
  logic [7:0] prev_err = 0;

  // Event monitor: samples 1 ns after each rising edge, cyc = edge index
  always @(posedge clk) begin
    cyc++;
    #1;
    if (sens_start) begin n_start++; start_cyc.push_back(cyc); end
    if (upd) begin n_upd++; upd_cyc.push_back(cyc); obs.push_back({temp, hum}); end
    if (fail) n_fail++;
    if ((sens_start && prev_s) || (upd && prev_u) || (fail && prev_f)) multi++;
    if (err_cnt != prev_err) err_cyc.push_back(cyc);
    prev_s = sens_start; prev_u = upd; prev_f = fail; prev_err = err_cnt;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(output int c0);
    c0 = cyc; btn = 1'b1; tick(3); btn = 1'b0; tick(1);
  endtask

  // Wait until start number nb+1 appears; returns its cycle or -1
  task automatic wait_start(input int nb, input int budget, output int sc);
    sc = -1;
    for (int i = 0; i < budget && n_start <= nb; i++) @(negedge clk);
    if (n_start > nb) sc = start_cyc[nb];
  endtask

  task automatic send(input logic [39:0] f, input bit live, output int c);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    if (live && sum == f[7:0]) expq.push_back({f[23:16], f[39:32]});
    frame = f; fv = 1'b1; c = cyc;
    tick(1);
    fv = 1'b0;
  endtask

  task automatic sb_drain(input string tag);
    chk({tag, "_sb_n"}, obs.size(), expq.size());
    while (obs.size() > 0 && expq.size() > 0) chk({tag, "_sb"}, obs.pop_front(), expq.pop_front());
    obs.delete(); expq.delete();
  endtask

  initial begin
    int c, c0, s, s2, sp, n0, f0, u0;
    // reset state
    tick(3);
    chk("rst_temp", temp, 0); chk("rst_hum", hum, 0); chk("rst_dv", data_valid, 0);
    chk("rst_err", err_cnt, 0); chk("rst_start", sens_start, 0);
    rst = 1'b0;
    tick(5);

    // 1: button read, good frame
    n0 = n_start;
    press(c0);
    wait_start(n0, 50, s);
    chk("t1_latency", s, c0 + 4);
    tick(300);
    send(40'h23_00_18_00_3B, 1, c);
    tick(200);
    chk("t1_upd_cyc", upd_cyc.size() > 0 ? upd_cyc[0] : -1, c + 2);
    chk("t1_temp", temp, 8'h18); chk("t1_hum", hum, 8'h23);
    chk("t1_dv", data_valid, 1); chk("t1_err", err_cnt, 0);
    chk("t1_nstart", n_start, 1); chk("t1_nupd", n_upd, 1);
    sb_drain("t1");

    // 2: bad checksum then good frame on retry
    n0 = n_start;
    press(c0);
    wait_start(n0, 50, s);
    tick(50);
    send(40'h23_00_18_00_3C, 1, c);
    wait_start(n0 + 1, 400, s2);
    chk("t2_retry_seen", s2 >= 0, 1);
    chk("t2_gap", (s2 - (c + 1)) >= G, 1);
    chk("t2_err", err_cnt, 1);
    tick(30);
    send(40'h2A_00_15_00_3F, 1, c);
    tick(200);
    chk("t2_temp", temp, 8'h15); chk("t2_hum", hum, 8'h2A);
    chk("t2_nupd", n_upd, 2); chk("t2_nstart", n_start - n0, 2);
    sb_drain("t2");

    // 3: no response -> three timed-out attempts, one fail
    n0 = n_start; f0 = n_fail;
    press(c0);
    tick(2200);
    chk("t3_nstart", n_start - n0, 3); chk("t3_nfail", n_fail - f0, 1);
    chk("t3_err", err_cnt, 4); chk("t3_dv", data_valid, 1); chk("t3_temp", temp, 8'h15);
    chk("t3_nerr", err_cyc.size() >= 3, 1);
    if (err_cyc.size() >= 3 && n_start - n0 >= 3)
      for (int k = 0; k < 3; k++)
        chk("t3_tmo", err_cyc[err_cyc.size() - 3 + k] - start_cyc[n0 + k], T);
    for (int k = 1; k < 3 && n_start - n0 >= 3; k++)
      chk("t3_spacing", start_cyc[n0 + k] - start_cyc[n0 + k - 1], T + 1 + G);

    // 4: requests during WAIT and GAP merge into one later read
    n0 = n_start;
    press(c0);
    wait_start(n0, 50, s);
    tick(20); press(c0); tick(20); press(c0); tick(50);
    send(40'h41_00_20_00_61, 1, c);
    tick(9); press(c0);
    wait_start(n0 + 1, 300, s2);
    chk("t4_second_seen", s2 >= 0, 1);
    chk("t4_after_gap", (s2 - (c + 2)) >= G, 1);
    tick(30);
    send(40'h42_00_21_00_63, 1, c);
    tick(700);
    chk("t4_nstart", n_start - n0, 2);
    chk("t4_temp", temp, 8'h21);
    sb_drain("t4");

    // 5: periodic requests
    n0 = n_start;
    auto_en = 1'b1;
    sp = -1;
    for (int k = 0; k < 3; k++) begin
      logic [39:0] f;
      wait_start(n0 + k, 2100, s);
      chk("t5_start_seen", s >= 0, 1);
      if (k > 0) chk("t5_period", s - sp, P);
      sp = s;
      f = {8'(8'h30 + k), 8'h00, 8'(8'h10 + k), 8'h00, 8'(8'h40 + 2 * k)};
      tick(20);
      send(f, 1, c);
    end
    auto_en = 1'b0;
    tick(3000);
    chk("t5_nstart", n_start - n0, 3);
    sb_drain("t5");

    // 6: reset mid-WAIT, late frame ignored
    n0 = n_start;
    press(c0);
    wait_start(n0, 50, s);
    tick(20);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t6_temp", temp, 0); chk("t6_hum", hum, 0); chk("t6_dv", data_valid, 0);
    chk("t6_err", err_cnt, 0); chk("t6_upd", upd, 0); chk("t6_fail", fail, 0);
    u0 = n_upd;
    tick(5);
    send(40'h23_00_18_00_3B, 0, c);
    tick(700);
    chk("t6_nupd", n_upd, u0); chk("t6_nstart", n_start - n0, 1);
    chk("t6_dv_late", data_valid, 0); chk("t6_temp_late", temp, 0);
    press(c0);
    wait_start(n0 + 1, 50, s);
    chk("t6_idle_latency", s, c0 + 4);
    tick(30);
    send(40'h23_00_18_00_3B, 1, c);
    tick(200);
    sb_drain("t6");

    chk("pulse_width", multi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dht11_read_scheduler.md
# dht11_read_scheduler

Sequences DHT11 measurement cycles for the sensor controller that drives the single-wire `data` line. Read requests come from the user button or an optional periodic timer. The block enforces the sensor's minimum inter-read gap, supervises each transaction with a timeout, validates the 40-bit frame checksum and retries failed reads. It presents the last good temperature/humidity pair to the display/UART side.

## Interface
- `MIN_GAP_CYC`, 200_000_000: minimum cycles between end of one attempt and next `sens_start` (2 s @ 100 MHz)
- `TIMEOUT_CYC`, 3_000_000: max cycles from `sens_start` to `sens_frame_valid` (30 ms)
- `PERIOD_CYC`, 500_000_000: auto-request period when `auto_en`=1
- `MAX_RETRY`, 3: extra attempts after a failed read (0..15)

Ports:
- `clk` in 1: system clock, 100 MHz
- `rst` in 1: synchronous, active-high reset
- `btn` in 1: raw asynchronous button, already debounced; rising edge = request
- `auto_en` in 1: enables periodic requests
- `sens_start` out 1: one-cycle pulse starting a sensor transaction
- `sens_frame_valid` in 1: one-cycle pulse, frame received
- `sens_frame` in 40: {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first; valid with the pulse
- `temp` out 8: last good temp_int
- `hum` out 8: last good hum_int
- `data_valid` out 1: level, high after the first good read
- `upd` out 1: one-cycle pulse when `temp`/`hum` update
- `fail` out 1: one-cycle pulse when all retries are exhausted
- `err_cnt` out 8: failed attempts (timeout or checksum), saturates at 255

## Operation
- Reset: state IDLE; all outputs 0; pending flag, retry count, gap/timeout/period counters cleared.
- `btn` passes through 2-FF synchronizer plus a third FF; request = ff2 & ~ff3.
- Periodic counter runs only while `auto_en`=1 and is cleared when `auto_en`=0. It issues a request when it reaches `PERIOD_CYC`-1, then wraps to 0.
- Request handling: a request in any state sets `pending`. Simultaneous or repeated requests merge into one. `pending` is cleared on IDLE→START.
- States:
  - IDLE: if `pending`, go to START.
  - START: `sens_start`=1 for this one cycle; clear timeout counter; go to WAIT.
  - WAIT: if `sens_frame_valid`, go to CHECK with the frame latched. Else if the timeout counter reaches `TIMEOUT_CYC`-1, count an error and go to RETRY.
  - CHECK: if (b4+b3+b2+b1) mod 256 == b0, load `temp`=b2 and `hum`=b4, set `data_valid`, pulse `upd`, clear retry count, go to GAP. Otherwise count an error and go to RETRY.
  - RETRY: if retry count < `MAX_RETRY`, increment it, set the internal `retry_req` and go to GAP. Otherwise pulse `fail`, clear retry count and `retry_req`, go to GAP.
  - GAP: count `MIN_GAP_CYC` cycles, then go to IDLE. If `retry_req` is set, go directly to START and clear `retry_req`.
- `sens_frame_valid` outside WAIT is ignored.
- A failed read never alters `temp`, `hum` or `data_valid`.
- Synchronous `rst` mid-transaction aborts immediately to the reset state. No `sens_start` is issued in the reset cycle or the cycle after it.

## Timing
- `btn` first sampled high at edge N gives `sens_start` high during the cycle after edge N+3.
- Request in IDLE registered at edge K gives `sens_start` in cycle K+1 to K+2.
- Timeout fires exactly `TIMEOUT_CYC` cycles after the `sens_start` cycle.
- Good frame: `upd` is high 2 cycles after the `sens_frame_valid` cycle; `temp`/`hum` change on the same edge.
- Gap between the end of one attempt and the next `sens_start` is always at least `MIN_GAP_CYC` cycles, including retries and button requests.
- All outputs are registered; `sens_start`, `upd` and `fail` are never high for more than 1 cycle.

## Test plan
Sim parameters: `MIN_GAP_CYC`=100, `TIMEOUT_CYC`=500, `PERIOD_CYC`=2000, `MAX_RETRY`=2.
- Button read, good frame: `btn` pulse, then frame 0x23_00_18_00_3B after 300 cycles → one `sens_start`; `temp`=0x18, `hum`=0x23, `data_valid`=1, one `upd`, `err_cnt`=0.
- Bad checksum: frame 0x23_00_18_00_3C, then a good frame on the first retry → `err_cnt`=1; second `sens_start` at least 100 cycles after CHECK; values update once.
- No response: no `sens_frame_valid` → 3 `sens_start` pulses, each attempt ends exactly 500 cycles after its start; one `fail`; `err_cnt`=3; `data_valid` unchanged.
- Request during busy/gap: `btn` pressed twice during WAIT and once during GAP → exactly one additional `sens_start`, issued after the gap expires.
- Periodic mode: `auto_en`=1 for 6000 cycles with good frames → 3 `sens_start` pulses at 2000-cycle spacing; clearing `auto_en` stops requests.
- Reset mid-WAIT: `rst` for 1 cycle, then a late `sens_frame_valid` → ignored; all outputs 0; state IDLE.
